// File: rtl/counter_ctrl_pkg.sv
// Shared opcode and state encodings for the counter run controller.
package counter_ctrl_pkg;
   localparam int OP_W = 3;
   localparam int ST_W = 2;

   localparam logic [OP_W-1:0] OP_NOP      = 3'd0;
   localparam logic [OP_W-1:0] OP_LOAD     = 3'd1;
   localparam logic [OP_W-1:0] OP_RUN_UP   = 3'd2;
   localparam logic [OP_W-1:0] OP_RUN_DOWN = 3'd3;
   localparam logic [OP_W-1:0] OP_PAUSE    = 3'd4;
   localparam logic [OP_W-1:0] OP_RESUME   = 3'd5;
   localparam logic [OP_W-1:0] OP_ABORT    = 3'd6;
   localparam logic [OP_W-1:0] OP_SET_RATE = 3'd7;

   localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
   localparam logic [ST_W-1:0] ST_RUN   = 2'd1;
   localparam logic [ST_W-1:0] ST_PAUSE = 2'd2;
   localparam logic [ST_W-1:0] ST_DONE  = 2'd3;

   // Commands that are rejected (err pulse, no effect) in a given state.
   function automatic logic op_illegal(input logic [ST_W-1:0] st, input logic [OP_W-1:0] op);
      logic run_cmd;
      run_cmd = (op == OP_LOAD) || (op == OP_RUN_UP) || (op == OP_RUN_DOWN);
      case (st)
         ST_RUN:   op_illegal = run_cmd || (op == OP_RESUME);
         ST_PAUSE: op_illegal = run_cmd || (op == OP_PAUSE);
         default:  op_illegal = (op == OP_PAUSE) || (op == OP_RESUME);
      endcase
   endfunction
endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..rate counter producing a one-cycle tick; freezes while hold is high.
module tick_prescaler #(
   parameter int PRESC_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               hold,
   input  logic [PRESC_W-1:0] rate,
   output logic               tick
);
   logic [PRESC_W-1:0] cnt_q;

   // >= rather than == so a rate lowered during PAUSE cannot strand the count above it.
   assign tick = (cnt_q >= rate);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     cnt_q <= '0;
      else if (clear) cnt_q <= '0;
      else if (!hold) cnt_q <= tick ? '0 : cnt_q + 1'b1;
   end
endmodule

// File: rtl/counter_run_ctrl.sv
// Command-driven sequencer pacing an external up/down counter toward a terminal value.
module counter_run_ctrl
   import counter_ctrl_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int PRESC_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [OP_W-1:0]  cmd_op,
   input  logic [WIDTH-1:0] cmd_arg,
   input  logic [WIDTH-1:0] cnt_value,
   output logic             cnt_en,
   output logic             cnt_up,
   output logic             cnt_load,
   output logic [WIDTH-1:0] cnt_load_val,
   output logic             busy,
   output logic             done,
   output logic             err
);
   logic [ST_W-1:0]    state_q, state_d;
   logic [PRESC_W-1:0] rate_q, rate_d;
   logic [WIDTH-1:0]   limit_q, limit_d;
   logic [WIDTH-1:0]   load_val_q, load_val_d;
   logic               up_q, up_d;
   logic               load_q, load_d;
   logic               err_q, err_d;
   logic               presc_clr, tick;
   logic               accept, run, at_limit;

   assign cmd_ready = ena;
   assign accept    = cmd_valid & ena;
   assign run       = (state_q == ST_RUN);
   assign at_limit  = (cnt_value == limit_q);

   tick_prescaler #(.PRESC_W(PRESC_W)) u_presc (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (presc_clr),
      .hold  (~(ena & run)),
      .rate  (rate_q),
      .tick  (tick)
   );

   always_comb begin
      state_d    = state_q;
      rate_d     = rate_q;
      limit_d    = limit_q;
      load_val_d = load_val_q;
      up_d       = up_q;
      load_d     = 1'b0;
      err_d      = accept & op_illegal(state_q, cmd_op);
      presc_clr  = 1'b0;
      case (state_q)
         ST_RUN: begin
            // ABORT wins, then the terminal match, then PAUSE.
            if (accept && cmd_op == OP_ABORT)   state_d = ST_IDLE;
            else if (ena && at_limit)           state_d = ST_DONE;
            else if (accept && cmd_op == OP_PAUSE) state_d = ST_PAUSE;
            if (accept && cmd_op == OP_SET_RATE) begin
               rate_d    = cmd_arg[PRESC_W-1:0];
               presc_clr = 1'b1;
            end
         end
         ST_PAUSE: if (accept) begin
            case (cmd_op)
               OP_RESUME:   state_d = ST_RUN;
               OP_ABORT:    state_d = ST_IDLE;
               OP_SET_RATE: rate_d  = cmd_arg[PRESC_W-1:0];
               default: ;
            endcase
         end
         default: if (accept) begin
            case (cmd_op)
               OP_LOAD: begin
                  load_d     = 1'b1;
                  load_val_d = cmd_arg;
                  state_d    = ST_IDLE;
               end
               OP_RUN_UP, OP_RUN_DOWN: begin
                  limit_d   = cmd_arg;
                  up_d      = (cmd_op == OP_RUN_UP);
                  presc_clr = 1'b1;
                  state_d   = ST_RUN;
               end
               OP_SET_RATE: rate_d  = cmd_arg[PRESC_W-1:0];
               OP_ABORT:    state_d = ST_IDLE;
               default: ;
            endcase
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         rate_q     <= '0;
         limit_q    <= '0;
         load_val_q <= '0;
         up_q       <= 1'b1;
         load_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rate_q     <= rate_d;
         limit_q    <= limit_d;
         load_val_q <= load_val_d;
         up_q       <= up_d;
         load_q     <= load_d;
         err_q      <= err_d;
      end
   end

   assign cnt_en       = ena & run & tick & ~at_limit & ~load_q;
   assign cnt_up       = up_q;
   assign cnt_load     = load_q;
   assign cnt_load_val = load_val_q;
   assign busy         = run | (state_q == ST_PAUSE);
   assign done         = (state_q == ST_DONE);
   assign err          = err_q;
endmodule

// File: tb/tb_counter_run_ctrl.sv
// Directed bench: drives commands and models the counter register fed by cnt_*.
module tb_counter_run_ctrl;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [2:0] cmd_op = 3'd0;
   logic [7:0] cmd_arg = 8'd0;
   logic [7:0] ctr;
   logic       cnt_en, cnt_up, cnt_load, busy, done, err;
   logic [7:0] cnt_load_val;
   int         en_cnt = 0;
   int         nvec = 0;
   int         nfail = 0;
   int         e0;

   always #5 clk = ~clk;

   counter_run_ctrl #(.WIDTH(8), .PRESC_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
      .cnt_value(ctr), .cnt_en(cnt_en), .cnt_up(cnt_up), .cnt_load(cnt_load),
      .cnt_load_val(cnt_load_val), .busy(busy), .done(done), .err(err)
   );

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)        ctr <= 8'd0;
      else if (cnt_load) ctr <= cnt_load_val;
      else if (cnt_en)   ctr <= cnt_up ? ctr + 8'd1 : ctr - 8'd1;
   end

   always @(posedge clk) if (cnt_en) en_cnt <= en_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; returns at the falling edge after the accepting rising edge.
   task automatic cmd(input logic [2:0] op, input logic [7:0] arg);
      cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
      @(negedge clk);
      cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = 8'd0;
   endtask

   task automatic wait_done(input int max);
      int i;
      i = 0;
      while (!done && i < max) begin @(negedge clk); i++; end
      chk("wait_done", done, 1);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
      chk("rst_err", err, 0);         chk("rst_load", cnt_load, 0);
      chk("rst_up", cnt_up, 1);       chk("rst_lval", cnt_load_val, 0);
      chk("rst_en", cnt_en, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready", cmd_ready, 1);

      // rate 0 run 0x10 -> 0x14
      cmd(3'd1, 8'h10);
      chk("t1_load", cnt_load, 1);    chk("t1_lval", cnt_load_val, 8'h10);
      cmd(3'd2, 8'h14);
      e0 = en_cnt;
      chk("t1_busy", busy, 1);        chk("t1_en0", cnt_en, 1);
      repeat (4) @(negedge clk);
      chk("t1_ctr", ctr, 8'h14);      chk("t1_steps", en_cnt - e0, 4);
      chk("t1_en_stop", cnt_en, 0);
      @(negedge clk);
      chk("t1_done", done, 1);        chk("t1_busy_off", busy, 0);

      // rate 3: a step every 4th RUN cycle
      cmd(3'd7, 8'h03);
      chk("t2_setrate_err", err, 0);
      cmd(3'd1, 8'h00);
      cmd(3'd2, 8'h02);
      chk("t2_ctr0", ctr, 0);
      for (int k = 1; k <= 8; k++) begin
         chk($sformatf("t2_en_c%0d", k), cnt_en, (k % 4 == 0));
         @(negedge clk);
      end
      chk("t2_ctr", ctr, 8'h02);
      @(negedge clk);
      chk("t2_done", done, 1);

      // wrap through 0xFF
      cmd(3'd7, 8'h00);
      cmd(3'd1, 8'hFE);
      cmd(3'd2, 8'h01);
      e0 = en_cnt;
      chk("t3_ctr_fe", ctr, 8'hFE);
      @(negedge clk); chk("t3_ctr_ff", ctr, 8'hFF);
      @(negedge clk); chk("t3_ctr_00", ctr, 8'h00);
      @(negedge clk); chk("t3_ctr_01", ctr, 8'h01);
      chk("t3_steps", en_cnt - e0, 3);
      @(negedge clk); chk("t3_done", done, 1);

      // count down with a pause
      cmd(3'd1, 8'h05);
      cmd(3'd3, 8'h00);
      e0 = en_cnt;
      chk("t4_dir", cnt_up, 0);
      @(negedge clk);
      cmd(3'd4, 8'h00);
      chk("t4_paused_busy", busy, 1); chk("t4_ctr_p", ctr, 8'h03);
      for (int k = 0; k < 10; k++) begin
         chk("t4_hold_en", cnt_en, 0);
         @(negedge clk);
      end
      chk("t4_ctr_hold", ctr, 8'h03);
      cmd(3'd5, 8'h00);
      chk("t4_resume_err", err, 0);
      wait_done(20);
      chk("t4_ctr_end", ctr, 8'h00);  chk("t4_steps", en_cnt - e0, 5);

      // illegal commands
      cmd(3'd1, 8'h00);
      cmd(3'd2, 8'h08);
      @(negedge clk);
      cmd(3'd1, 8'h55);
      chk("t5_err", err, 1);          chk("t5_noload", cnt_load, 0);
      chk("t5_busy", busy, 1);        chk("t5_ctr", ctr, 8'h02);
      @(negedge clk);
      chk("t5_err_pulse", err, 0);
      wait_done(20);
      chk("t5_ctr_end", ctr, 8'h08);
      cmd(3'd6, 8'h00);
      chk("t5_abort_noerr", err, 0);  chk("t5_idle", done, 0);
      cmd(3'd4, 8'h00);
      chk("t5_pause_idle_err", err, 1);
      chk("t5_pause_idle_busy", busy, 0);

      // ena freeze with rate 1, then async reset mid-run
      cmd(3'd7, 8'h01);
      cmd(3'd1, 8'h40);
      cmd(3'd2, 8'h60);
      chk("t6_en_c1", cnt_en, 0);
      @(negedge clk); chk("t6_en_c2", cnt_en, 1);
      @(negedge clk); chk("t6_ctr", ctr, 8'h41);
      @(negedge clk); chk("t6_en_c4", cnt_en, 1);
      ena = 1'b0;
      #1;
      chk("t6_en_off", cnt_en, 0);    chk("t6_ready_off", cmd_ready, 0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("t6_frozen_en", cnt_en, 0);
         chk("t6_frozen_busy", busy, 1);
      end
      chk("t6_ctr_frozen", ctr, 8'h41);
      ena = 1'b1;
      #1;
      chk("t6_presc_kept", cnt_en, 1);
      @(negedge clk);
      chk("t6_ctr_step", ctr, 8'h42);
      rst_n = 1'b0;
      #1;
      chk("t7_busy", busy, 0);        chk("t7_en", cnt_en, 0);
      chk("t7_lval", cnt_load_val, 0); chk("t7_up", cnt_up, 1);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
